// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB memory completer:
//   apb_state_e     - transfer FSM states
//   WAIT_STATES_MAX - largest supported number of access-phase wait states
//   lane_shift()    - log2 of the number of byte lanes in a data word, i.e.
//                     the number of low PADDR bits that select a byte within
//                     a word
// -----------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP_SEEN,
      WAIT,
      DONE
   } apb_state_e;

   localparam int WAIT_STATES_MAX = 15;

   // Only 8/16/32-bit data widths are meaningful (1, 2 or 4 byte lanes).
   function automatic int lane_shift(input int data_width);
      int bytes;
      int s;
      bytes = data_width / 8;
      s     = 0;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) == bytes) begin
            s = i;
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/apb_mem_array.sv
// -----------------------------------------------------------------------------
// apb_mem_array
// DEPTH x DATA_WIDTH word storage with one asynchronous read port and one
// synchronous write port with per-byte write enables. Each byte lane is its
// own array so a lane write never needs a read-modify-write, and the whole
// block can later be replaced by a vendor memory macro.
//
// Ports:
//   clk    in   write clock
//   waddr  in   word index for the write port
//   wbe    in   per-byte write enables (all zero = no write)
//   wdata  in   write data
//   raddr  in   word index for the read port
//   rdata  out  read data, combinational from raddr
// Contents are not reset.
// -----------------------------------------------------------------------------
module apb_mem_array #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = 6
) (
   input  logic                    clk,
   input  logic [IDX_W-1:0]        waddr,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [IDX_W-1:0]        raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB = DATA_WIDTH / 8;

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
         if (wbe[gi]) begin
            lane_mem[waddr] <= wdata[gi*8 +: 8];
         end
      end

      assign rdata[gi*8 +: 8] = lane_mem[raddr];
   end

endmodule

// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
// APB completer backed by a word-organised memory. Supports programmable
// access-phase wait states, byte write strobes and an error response for
// accesses whose word index falls outside the memory.
//
// Parameters:
//   ADDR_WIDTH  byte-address width of PADDR
//   DATA_WIDTH  8, 16 or 32
//   DEPTH       number of DATA_WIDTH words
//   WAIT_STATES extra access-phase cycles before PREADY (0..15)
//
// Ports:
//   PCLK     in   clock
//   PRESET   in   asynchronous active-high reset
//   PSEL     in   completer select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address
//   PWDATA   in   write data
//   PSTRB    in   byte write strobes (ignored on reads)
//   PRDATA   out  registered read data, held until the next read completes
//   PREADY   out  registered transfer-complete, one cycle per transfer
//   PSLVERR  out  registered error response, meaningful only with PREADY
// -----------------------------------------------------------------------------
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int SHIFT = lane_shift(DATA_WIDTH);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(WAIT_STATES_MAX + 1);

   // Word index and range check of the address currently on the bus.
   // The compare is done one bit wider so DEPTH == 2**ADDR_WIDTH still works.
   logic [ADDR_WIDTH-1:0] bus_idx;
   logic                  bus_err;

   assign bus_idx = PADDR >> SHIFT;
   assign bus_err = {1'b0, bus_idx} >= (ADDR_WIDTH + 1)'(DEPTH);

   apb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [NB-1:0]         mem_wbe;

   logic                  setup;
   logic                  finish;
   logic                  fin_err;
   logic                  fin_write;

   // With zero wait states the read data is captured at the end of the
   // setup cycle, before the index has been latched, so the read port looks
   // at the live bus address in IDLE/DONE and at the latched index while
   // waiting.
   assign rd_idx = (state_q == IDLE || state_q == DONE) ? bus_idx[IDX_W-1:0] : idx_q;

   // The write happens at the end of the single DONE cycle, using the data
   // and strobes presented during that cycle.
   assign mem_wbe = (state_q == DONE && write_q && !err_q) ? PSTRB : '0;

   assign setup = PSEL && !PENABLE;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      write_d   = write_q;
      err_d     = err_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = prdata_q;
      finish    = 1'b0;
      fin_err   = 1'b0;
      fin_write = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (setup) begin
               idx_d   = bus_idx[IDX_W-1:0];
               write_d = PWRITE;
               err_d   = bus_err;
               if (WAIT_STATES == 0) begin
                  state_d   = DONE;
                  cnt_d     = '0;
                  finish    = 1'b1;
                  fin_err   = bus_err;
                  fin_write = PWRITE;
               end else begin
                  state_d = SETUP_SEEN;
                  cnt_d   = CNT_W'(WAIT_STATES);
               end
            end else begin
               // Also covers PENABLE without a preceding setup: ignored.
               state_d = IDLE;
               cnt_d   = '0;
            end
         end

         SETUP_SEEN, WAIT: begin
            if (!PSEL) begin
               // Abort: drop the transfer silently, no response, no write.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (PENABLE) begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d   = DONE;
                  cnt_d     = '0;
                  finish    = 1'b1;
                  fin_err   = err_q;
                  fin_write = write_q;
               end else begin
                  state_d = WAIT;
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Response registers are loaded on the edge that enters DONE.
      if (finish) begin
         pready_d  = 1'b1;
         pslverr_d = fin_err;
         if (!fin_write) begin
            prdata_d = fin_err ? '0 : mem_rdata;
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         write_q   <= write_d;
         err_q     <= err_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   apb_mem_array #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_mem (
      .clk   (PCLK),
      .waddr (idx_q),
      .wbe   (mem_wbe),
      .wdata (PWDATA),
      .raddr (rd_idx),
      .rdata (mem_rdata)
   );

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
// Two completers share one APB bus: instance 0 with no wait states, instance 1
// with three. Expected responses are pushed to a queue when a transfer is
// issued and popped when PREADY rises.
// -----------------------------------------------------------------------------
module tb_apb_mem_slave;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata  [2];
   logic        pready  [2];
   logic        pslverr [2];

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          last_ready_cyc;
   exp_t        exp_q [$];
   logic [31:0] model   [2][64];
   logic [31:0] last_rd [2];

   apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_dut0 (
      .PCLK    (clk),
      .PRESET  (rst),
      .PSEL    (psel[0]),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PSTRB   (pstrb),
      .PRDATA  (prdata[0]),
      .PREADY  (pready[0]),
      .PSLVERR (pslverr[0])
   );

   apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u_dut3 (
      .PCLK    (clk),
      .PRESET  (rst),
      .PSEL    (psel[1]),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PSTRB   (pstrb),
      .PRDATA  (prdata[1]),
      .PREADY  (pready[1]),
      .PSLVERR (pslverr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transfer on instance k; returns one cycle after PREADY
   // with the bus idle so a following call is back-to-back.
   task automatic xfer(input int k, input logic wr, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
      exp_t e;
      int   idx;
      int   n;
      int   ws;
      ws    = (k == 0) ? 0 : 3;
      idx   = int'(addr >> 2);
      e.err = (idx >= 64);
      if (wr) begin
         e.rdata = last_rd[k];
         if (!e.err) begin
            for (int i = 0; i < 4; i++) begin
               if (st[i]) model[k][idx][8*i +: 8] = wd[8*i +: 8];
            end
         end
      end else begin
         e.rdata    = e.err ? 32'h0 : model[k][idx];
         last_rd[k] = e.rdata;
      end
      exp_q.push_back(e);

      psel    = 2'b00;
      psel[k] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wd;
      pstrb   = st;
      step();
      penable = 1'b1;
      n = 1;
      while (pready[k] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check($sformatf("ACC_CYCLES k=%0d a=%h", k, addr), n, ws + 1);
      e = exp_q.pop_front();
      check($sformatf("PRDATA k=%0d a=%h", k, addr), prdata[k], e.rdata);
      check($sformatf("PSLVERR k=%0d a=%h", k, addr), {31'b0, pslverr[k]}, {31'b0, e.err});
      $display("xfer k=%0d %s addr=%h wdata=%h strb=%h prdata=%h err=%0d acc=%0d",
               k, wr ? "WR" : "RD", addr, wd, st, prdata[k], pslverr[k], n);
      last_ready_cyc = cyc;
      step();
      psel    = 2'b00;
      penable = 1'b0;
      check($sformatf("PREADY_DROP k=%0d", k), {31'b0, pready[k]}, 32'h0);
   endtask

   initial begin
      int r0, r1, r2;
      rst = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      last_rd[0] = '0; last_rd[1] = '0;
      repeat (3) step();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("RST_PREADY k=%0d", k), {31'b0, pready[k]}, 32'h0);
         check($sformatf("RST_PSLVERR k=%0d", k), {31'b0, pslverr[k]}, 32'h0);
         check($sformatf("RST_PRDATA k=%0d", k), prdata[k], 32'h0);
      end
      rst = 1'b0;
      step();

      // Fill instance 0 with a known pattern.
      for (int i = 0; i < 64; i++) begin
         xfer(0, 1'b1, 12'(i * 4), {8'hA5, 8'(i), 8'(~i), 8'(i * 3)}, 4'hF);
      end

      // Full write then immediate read-back.
      xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
      xfer(0, 1'b0, 12'h010, 32'h0, 4'h0);
      check("RD_DEADBEEF", prdata[0], 32'hDEADBEEF);

      // Byte strobes: lanes 0 and 2 only.
      xfer(0, 1'b1, 12'h010, 32'h11223344, 4'h5);
      xfer(0, 1'b0, 12'h010, 32'h0, 4'hF);
      check("RD_STRB", prdata[0], 32'hDE22BE44);

      // Three wait states.
      xfer(1, 1'b1, 12'h020, 32'hCAFEF00D, 4'hF);
      xfer(1, 1'b0, 12'h020, 32'h0, 4'h0);
      check("RD_WS3", prdata[1], 32'hCAFEF00D);

      // Out of range: index 64.
      xfer(0, 1'b1, 12'h100, 32'h12345678, 4'hF);
      xfer(0, 1'b0, 12'h100, 32'h0, 4'h0);
      check("OOR_PRDATA", prdata[0], 32'h0);
      for (int i = 0; i < 64; i++) begin
         xfer(0, 1'b0, 12'(i * 4), 32'h0, 4'h0);
      end

      // Abort a write in its second wait cycle.
      xfer(1, 1'b1, 12'h004, 32'h00004444, 4'hF);
      psel = 2'b10; penable = 1'b0; pwrite = 1'b1;
      paddr = 12'h004; pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
      step();
      penable = 1'b1;
      check("ABORT_WAIT1", {31'b0, pready[1]}, 32'h0);
      step();
      check("ABORT_WAIT2", {31'b0, pready[1]}, 32'h0);
      psel = 2'b00; penable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("ABORT_NORDY", {31'b0, pready[1]}, 32'h0);
         check("ABORT_NOERR", {31'b0, pslverr[1]}, 32'h0);
      end
      $display("abort k=1 WR addr=004 wdata=bad0bad0 dropped in wait cycle 2");
      xfer(1, 1'b0, 12'h004, 32'h0, 4'h0);

      // Reset in the middle of a read.
      xfer(1, 1'b0, 12'h020, 32'h0, 4'h0);
      check("PRE_RST_PRDATA", prdata[1], 32'hCAFEF00D);
      psel = 2'b10; penable = 1'b0; pwrite = 1'b0; paddr = 12'h020;
      step();
      penable = 1'b1;
      step();
      rst = 1'b1;
      #1;
      check("MIDRST_PREADY", {31'b0, pready[1]}, 32'h0);
      check("MIDRST_PSLVERR", {31'b0, pslverr[1]}, 32'h0);
      check("MIDRST_PRDATA1", prdata[1], 32'h0);
      check("MIDRST_PRDATA0", prdata[0], 32'h0);
      $display("reset asserted mid-read k=1 addr=020 prdata=%h", prdata[1]);
      psel = 2'b00; penable = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;
      step();
      step();
      rst = 1'b0;
      step();
      xfer(1, 1'b0, 12'h020, 32'h0, 4'h0);

      // Back-to-back reads with no idle cycles.
      xfer(0, 1'b0, 12'h000, 32'h0, 4'h0);
      r0 = last_ready_cyc;
      xfer(0, 1'b0, 12'h004, 32'h0, 4'h0);
      r1 = last_ready_cyc;
      xfer(0, 1'b0, 12'h008, 32'h0, 4'h0);
      r2 = last_ready_cyc;
      check("B2B_GAP1", r1 - r0, 2);
      check("B2B_GAP2", r2 - r1, 2);

      if (exp_q.size() != 0) begin
         check("SB_EMPTY", exp_q.size(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
